// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles the CPU, debug and data-memory buses around the shared-memory arbiter.
// slave modport is the arbiter's view; master modport is the requester/memory environment view.
// Pure signal container, no logic.
interface dmem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  logic        dbg_req;
  logic        dbg_we;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;

  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_stall, dbg_ack, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_stall, dbg_ack, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the pipeline memory stage (CPU) and a debug port.
// Latency: writes complete in the issue cycle; reads complete WAIT_CYCLES cycles after issue.
// Backpressure: cpu_stall holds the pipeline, dbg_ack completes a held debug request.
// Optional starvation guard enabled by defining DMEM_ARB_STARVE_GUARD_EN.
module dmem_arbiter #(
  parameter int WAIT_CYCLES  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CPU_RD, DBG_RD} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);
  localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);

  generate
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("dmem_arbiter: WAIT_CYCLES out of range 0..15");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
      $error("dmem_arbiter: STARVE_LIMIT out of range 1..15");
    end
  endgenerate

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [31:0] lat_addr, lat_wdata;
  logic [31:0] cpu_rdata_q, dbg_rdata_q;

  logic force_dbg, cpu_gnt, dbg_gnt, rd_last;
  logic cpu_rd_gnt, dbg_rd_gnt;
  logic cpu_rd_done, dbg_rd_done, cpu_done, dbg_done;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  logic [3:0] starve;

  assign force_dbg = bus.dbg_req && (starve == STARVE_MAX);

  // count CPU grants made while debug waits; clear once debug is served or idle
  always_ff @(posedge clk) begin
    if (rst)
      starve <= 4'd0;
    else if (!bus.dbg_req || dbg_gnt)
      starve <= 4'd0;
    else if (cpu_gnt && starve != STARVE_MAX)
      starve <= starve + 4'd1;
  end
`else
  assign force_dbg = 1'b0;
`endif

  // Arbitration only in IDLE; the CPU wins unless the guard forces the debug port.
  assign cpu_gnt    = (state == IDLE) && bus.cpu_req && !force_dbg;
  assign dbg_gnt    = (state == IDLE) && bus.dbg_req && (!bus.cpu_req || force_dbg);
  assign cpu_rd_gnt = cpu_gnt && !bus.cpu_we;
  assign dbg_rd_gnt = dbg_gnt && !bus.dbg_we;
  assign rd_last    = (cnt == WAIT_LAST);

  // Completions are suppressed during reset so an aborted read never reports data.
  assign cpu_rd_done = !rst && ((cpu_rd_gnt && ZERO_WAIT) || (state == CPU_RD && rd_last));
  assign dbg_rd_done = !rst && ((dbg_rd_gnt && ZERO_WAIT) || (state == DBG_RD && rd_last));
  assign cpu_done    = cpu_rd_done || (!rst && cpu_gnt && bus.cpu_we);
  assign dbg_done    = dbg_rd_done || (!rst && dbg_gnt && bus.dbg_we);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state: enter a read state only for reads that need wait cycles
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cpu_rd_gnt && !ZERO_WAIT)      state_nxt = CPU_RD;
        else if (dbg_rd_gnt && !ZERO_WAIT) state_nxt = DBG_RD;
      end
      CPU_RD, DBG_RD: begin
        if (rd_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // outputs: memory drive from the winner in IDLE, from the latched request in read states
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 32'd0;
    bus.mem_wdata = 32'd0;
    bus.cpu_stall = 1'b0;
    bus.dbg_ack   = 1'b0;
    if (!rst) begin
      if (state == IDLE) begin
        if (cpu_gnt) begin
          bus.mem_en    = 1'b1;
          bus.mem_we    = bus.cpu_we;
          bus.mem_addr  = bus.cpu_addr;
          bus.mem_wdata = bus.cpu_wdata;
        end else if (dbg_gnt) begin
          bus.mem_en    = 1'b1;
          bus.mem_we    = bus.dbg_we;
          bus.mem_addr  = bus.dbg_addr;
          bus.mem_wdata = bus.dbg_wdata;
        end
      end else begin
        bus.mem_en    = 1'b1;
        bus.mem_addr  = lat_addr;
        bus.mem_wdata = lat_wdata;
      end
      bus.cpu_stall = bus.cpu_req && !cpu_done;
      bus.dbg_ack   = dbg_done;
    end
    bus.cpu_rdata = cpu_rd_done ? bus.mem_rdata : cpu_rdata_q;
    bus.dbg_rdata = dbg_rd_done ? bus.mem_rdata : dbg_rdata_q;
  end

  // datapath: latch the winner, run the wait counter, capture read data at completion
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= 4'd0;
      lat_addr    <= 32'd0;
      lat_wdata   <= 32'd0;
      cpu_rdata_q <= 32'd0;
      dbg_rdata_q <= 32'd0;
    end else begin
      if (cpu_gnt) begin
        lat_addr  <= bus.cpu_addr;
        lat_wdata <= bus.cpu_wdata;
      end else if (dbg_gnt) begin
        lat_addr  <= bus.dbg_addr;
        lat_wdata <= bus.dbg_wdata;
      end
      if (state == IDLE)
        cnt <= ((cpu_rd_gnt || dbg_rd_gnt) && !ZERO_WAIT) ? 4'd1 : 4'd0;
      else
        cnt <= rd_last ? 4'd0 : cnt + 4'd1;
      if (cpu_rd_done) cpu_rdata_q <= bus.mem_rdata;
      if (dbg_rd_done) dbg_rdata_q <= bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed table, hand sequences (starvation, zero-wait) and a randomized run
// checked against a transaction-level model. Memory read data is a fixed function of the address.
// Build with DMEM_ARB_STARVE_GUARD_EN defined to exercise the starvation guard expectations.
module tb_dmem_arbiter;
  localparam int W   = 2;
  localparam int LIM = 4;
`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();
  dmem_arbiter_if bus0 ();

  logic        use_fixed;
  logic [31:0] mem_fixed;

  function automatic logic [31:0] rdfn(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  assign bus.mem_rdata  = use_fixed ? mem_fixed : rdfn(bus.mem_addr);
  assign bus0.mem_rdata = rdfn(bus0.mem_addr);

  dmem_arbiter #(.WAIT_CYCLES(W), .STARVE_LIMIT(LIM)) dut  (.clk(clk), .rst(rst), .bus(bus));
  dmem_arbiter #(.WAIT_CYCLES(0), .STARVE_LIMIT(LIM)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
    bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
    bus.dbg_req = dr; bus.dbg_we = dw; bus.dbg_addr = da; bus.dbg_wdata = dd;
  endtask

  typedef struct {
    logic        r, cr, cw;
    logic [31:0] ca, cd;
    logic        dr;
    logic [31:0] da;
    logic        en, we;
    logic [31:0] addr, wd;
    logic        st, ak, ck;
    logic [31:0] rd;
  } vec_t;

  function automatic vec_t mkv(input logic r, input logic cr, input logic cw,
                               input logic [31:0] ca, input logic [31:0] cd,
                               input logic dr, input logic [31:0] da,
                               input logic en, input logic we,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic st, input logic ak, input logic ck,
                               input logic [31:0] rd);
    vec_t v;
    v.r = r; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd; v.dr = dr; v.da = da;
    v.en = en; v.we = we; v.addr = addr; v.wd = wd; v.st = st; v.ak = ak; v.ck = ck; v.rd = rd;
    return v;
  endfunction

  vec_t vt[14];
  localparam logic [31:0] D = 32'hDEADBEEF;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int ngr, ack_at;
    int owner, left, starve, win;
    logic [31:0] lat, m_cpu_rd, m_dbg_rd;
    bit c_req, c_we, d_req, d_we, c_hold, d_hold;
    logic [31:0] c_addr, c_wd, d_addr, d_wd;

    //           r  cr cw ca     cd      dr da     en we addr   wd      st ak ck rd
    vt[0]  = mkv(0, 1, 0, 32'h10, 0,      0, 0,     1, 0, 32'h10, 0,      1, 0, 1, 0);
    vt[1]  = mkv(0, 1, 0, 32'h10, 0,      0, 0,     1, 0, 32'h10, 0,      1, 0, 1, 0);
    vt[2]  = mkv(0, 1, 0, 32'h10, 0,      0, 0,     1, 0, 32'h10, 0,      0, 0, 1, D);
    vt[3]  = mkv(0, 1, 1, 32'h20, 32'h1234, 0, 0,   1, 1, 32'h20, 32'h1234, 0, 0, 1, D);
    vt[4]  = mkv(0, 0, 0, 0,      0,      1, 32'h40, 1, 0, 32'h40, 0,      0, 0, 1, D);
    vt[5]  = mkv(0, 1, 0, 32'h50, 0,      1, 32'h40, 1, 0, 32'h40, 0,      1, 0, 1, D);
    vt[6]  = mkv(0, 1, 0, 32'h50, 0,      1, 32'h40, 1, 0, 32'h40, 0,      1, 1, 1, D);
    vt[7]  = mkv(0, 1, 0, 32'h50, 0,      0, 0,     1, 0, 32'h50, 0,      1, 0, 1, D);
    vt[8]  = mkv(0, 1, 0, 32'h50, 0,      0, 0,     1, 0, 32'h50, 0,      1, 0, 1, D);
    vt[9]  = mkv(0, 1, 0, 32'h50, 0,      0, 0,     1, 0, 32'h50, 0,      0, 0, 1, D);
    vt[10] = mkv(0, 0, 0, 0,      0,      0, 0,     0, 0, 0,      0,      0, 0, 1, D);
    vt[11] = mkv(0, 1, 0, 32'h60, 0,      0, 0,     1, 0, 32'h60, 0,      1, 0, 1, D);
    vt[12] = mkv(1, 1, 0, 32'h60, 0,      0, 0,     0, 0, 0,      0,      0, 0, 0, 0);
    vt[13] = mkv(0, 0, 0, 0,      0,      0, 0,     0, 0, 0,      0,      0, 0, 1, 0);

    use_fixed = 1'b1;
    mem_fixed = D;
    bus0.cpu_req = 0; bus0.cpu_we = 0; bus0.cpu_addr = 0; bus0.cpu_wdata = 0;
    bus0.dbg_req = 0; bus0.dbg_we = 0; bus0.dbg_addr = 0; bus0.dbg_wdata = 0;

    // reset: combinational outputs forced low even with requests present
    rst = 1'b1;
    drive(1, 1, 32'hAAAA_0000, 32'h5555_0000, 1, 1, 32'h1, 32'h2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_cpu_stall", bus.cpu_stall, 0);
    chk("rst_dbg_ack", bus.dbg_ack, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_cpu_rdata", bus.cpu_rdata, 0);
    chk("rst_dbg_rdata", bus.dbg_rdata, 0);
    chk("idle_mem_en", bus.mem_en, 0);
    @(posedge clk); #1;

    // directed table
    for (int i = 0; i < 14; i++) begin
      rst = vt[i].r;
      drive(vt[i].cr, vt[i].cw, vt[i].ca, vt[i].cd, vt[i].dr, 1'b0, vt[i].da, 32'h0);
      @(negedge clk);
      chk($sformatf("v%0d_mem_en", i), bus.mem_en, vt[i].en);
      chk($sformatf("v%0d_mem_we", i), bus.mem_we, vt[i].we);
      chk($sformatf("v%0d_cpu_stall", i), bus.cpu_stall, vt[i].st);
      chk($sformatf("v%0d_dbg_ack", i), bus.dbg_ack, vt[i].ak);
      if (vt[i].en || vt[i].r) chk($sformatf("v%0d_mem_addr", i), bus.mem_addr, vt[i].addr);
      if (vt[i].we || vt[i].r) chk($sformatf("v%0d_mem_wdata", i), bus.mem_wdata, vt[i].wd);
      if (vt[i].ck) chk($sformatf("v%0d_cpu_rdata", i), bus.cpu_rdata, vt[i].rd);
      if (vt[i].ak) chk($sformatf("v%0d_dbg_rdata", i), bus.dbg_rdata, D);
      if (i == 13) chk("v13_dbg_rdata_cleared", bus.dbg_rdata, 0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    use_fixed = 1'b0;

    // starvation: continuous CPU writes with a pending debug write
    ngr = 0;
    ack_at = 0;
    for (int c = 1; c <= 12; c++) begin
      drive(1, 1, 32'h100 + 32'(4 * c), 32'(c), (ack_at == 0), 1, 32'h80, 32'hCAFE);
      @(negedge clk);
      if (bus.dbg_ack && ack_at == 0) begin
        ack_at = c;
        chk("starve_ack_stall", bus.cpu_stall, 1);
        chk("starve_ack_addr", bus.mem_addr, 32'h80);
        chk("starve_ack_wdata", bus.mem_wdata, 32'hCAFE);
      end else if (ack_at == 0 && !bus.cpu_stall) begin
        ngr++;
      end
      @(posedge clk); #1;
    end
`ifdef DMEM_ARB_STARVE_GUARD_EN
    chk("starve_cpu_grants", 32'(ngr), 32'(LIM));
    chk("starve_ack_cycle", 32'(ack_at), 32'(LIM + 1));
`else
    chk("strict_cpu_grants", 32'(ngr), 32'd12);
    chk("strict_no_ack", 32'(ack_at), 32'd0);
    drive(0, 0, 0, 0, 1, 1, 32'h80, 32'hCAFE);
    @(negedge clk);
    chk("strict_ack_after_cpu_idle", bus.dbg_ack, 1);
    chk("strict_ack_we", bus.mem_we, 1);
    @(posedge clk); #1;
`endif
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // zero wait cycles: reads complete in the issue cycle
    bus0.cpu_req = 1; bus0.cpu_we = 0; bus0.cpu_addr = 32'h70;
    @(negedge clk);
    chk("w0_cpu_stall", bus0.cpu_stall, 0);
    chk("w0_mem_en", bus0.mem_en, 1);
    chk("w0_cpu_rdata", bus0.cpu_rdata, rdfn(32'h70));
    @(posedge clk); #1;
    bus0.cpu_req = 0;
    bus0.dbg_req = 1; bus0.dbg_we = 0; bus0.dbg_addr = 32'h74;
    @(negedge clk);
    chk("w0_dbg_ack", bus0.dbg_ack, 1);
    chk("w0_dbg_rdata", bus0.dbg_rdata, rdfn(32'h74));
    chk("w0_cpu_rdata_held", bus0.cpu_rdata, rdfn(32'h70));
    @(posedge clk); #1;
    bus0.dbg_req = 0;

    // randomized run against a transaction-level model
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    owner = 0; left = 0; starve = 0; lat = 0; m_cpu_rd = 0; m_dbg_rd = 0;
    c_hold = 0; d_hold = 0;
    c_req = 0; c_we = 0; c_addr = 0; c_wd = 0; d_req = 0; d_we = 0; d_addr = 0; d_wd = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      bit e_en, e_we, dc, dd, rdc;
      logic [31:0] e_addr, e_wd, rd_addr, e_crd, e_drd;
      int owner_n, left_n, starve_n;
      logic [31:0] lat_n;
      if (c_hold) begin
        if ($urandom_range(99) < 3) c_req = 0;
      end else begin
        c_req = ($urandom_range(99) < 60);
        c_we = 1'($urandom_range(1));
        c_addr = $urandom & 32'h0000_0FFC;
        c_wd = $urandom;
      end
      if (!d_hold) begin
        d_req = ($urandom_range(99) < 30);
        d_we = 1'($urandom_range(1));
        d_addr = $urandom & 32'h0000_0FFC;
        d_wd = $urandom;
      end
      drive(c_req, c_we, c_addr, c_wd, d_req, d_we, d_addr, d_wd);
      @(negedge clk);

      e_en = 0; e_we = 0; e_addr = 0; e_wd = 0; dc = 0; dd = 0; rdc = 0; rd_addr = 0;
      owner_n = owner; left_n = left; lat_n = lat; starve_n = starve;
      if (owner == 0) begin
        win = 0;
        if (c_req && !(GUARD && d_req && starve >= LIM)) win = 1;
        else if (d_req) win = 2;
        if (win != 0) begin
          e_en = 1;
          e_we = (win == 1) ? c_we : d_we;
          e_addr = (win == 1) ? c_addr : d_addr;
          e_wd = (win == 1) ? c_wd : d_wd;
          if (e_we || W == 0) begin
            dc = (win == 1); dd = (win == 2); rdc = !e_we; rd_addr = e_addr;
          end else begin
            owner_n = win; left_n = W; lat_n = e_addr;
          end
        end
        if (!d_req || win == 2) starve_n = 0;
        else if (win == 1 && starve < LIM) starve_n = starve + 1;
      end else begin
        e_en = 1;
        e_addr = lat;
        if (left == 1) begin
          dc = (owner == 1); dd = (owner == 2); rdc = 1; rd_addr = lat; owner_n = 0;
        end else begin
          left_n = left - 1;
        end
        if (!d_req) starve_n = 0;
      end
      e_crd = (dc && rdc) ? rdfn(rd_addr) : m_cpu_rd;
      e_drd = (dd && rdc) ? rdfn(rd_addr) : m_dbg_rd;

      chk($sformatf("r%0d_mem_en", cyc), bus.mem_en, e_en);
      chk($sformatf("r%0d_mem_we", cyc), bus.mem_we, e_we);
      if (e_en) chk($sformatf("r%0d_mem_addr", cyc), bus.mem_addr, e_addr);
      if (e_we) chk($sformatf("r%0d_mem_wdata", cyc), bus.mem_wdata, e_wd);
      chk($sformatf("r%0d_cpu_stall", cyc), bus.cpu_stall, c_req && !dc);
      chk($sformatf("r%0d_dbg_ack", cyc), bus.dbg_ack, dd);
      chk($sformatf("r%0d_cpu_rdata", cyc), bus.cpu_rdata, e_crd);
      chk($sformatf("r%0d_dbg_rdata", cyc), bus.dbg_rdata, e_drd);

      m_cpu_rd = e_crd; m_dbg_rd = e_drd;
      owner = owner_n; left = left_n; lat = lat_n; starve = starve_n;
      c_hold = c_req && !dc;
      d_hold = d_req && !dd;
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
